im_loader: RTL and testbench

- Writer side of the 4 KB instruction memory: receives a framed byte stream and writes 32-bit instruction words into the memory's write port, starting at word address 0.
- Holds the CPU in reset while loading.
- Replaces the simulation-only hex file load with a runtime load path, e.g. from a UART receiver.
- Sits between the byte source and the instruction memory write port, and drives the CPU reset gate.

---
 rtl/im_loader.sv | 157 +++++++++++++++
 tb/tb_im_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module      : im_loader
// Description : Runtime loader for the 4 KB instruction memory. Parses a
//               framed byte stream (16-bit word count, big-endian payload
//               words, XOR checksum byte) and writes 32-bit words into the
//               memory write port from word address 0 upward. Holds the CPU
//               in reset for the duration of the load.
// Revision    : 1.0 - initial release
// ============================================================================
module im_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [10:0]       words_written,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [10:0] c_max_words = 11'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t      r_state;
  logic [7:0]  r_len_hi;   // high length byte, held until the low byte arrives
  logic [10:0] r_len;      // accepted frame length in words
  logic [10:0] r_widx;     // index of the word currently being assembled
  logic [1:0]  r_bcnt;     // byte position within the current word
  logic [23:0] r_asm;      // first three bytes of the current word
  logic [7:0]  r_csum;     // running XOR of payload bytes

  logic [10:0] w_len;
  logic        w_len_ok;
  logic        w_last_word;

  // Length as seen on the LEN_LO byte; the top five bits of the high byte must be zero.
  assign w_len       = {r_len_hi[2:0], byte_data};
  assign w_len_ok    = (r_len_hi[7:3] == 5'd0) && (w_len != 11'd0) && (w_len <= c_max_words);
  assign w_last_word = ((r_widx + 11'd1) == r_len);

  // Byte acceptance depends only on state so the source never sees a combinational loop.
  always_comb begin
    byte_ready = 1'b0;
    case (r_state)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK: byte_ready = 1'b1;
      default:                             byte_ready = 1'b0;
    endcase
  end

  // The CPU stays in reset exactly as long as a load is in progress.
  assign cpu_hold = busy;

  // Frame parser FSM with registered memory-port and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_len_hi      <= 8'd0;
      r_len         <= 11'd0;
      r_widx        <= 11'd0;
      r_bcnt        <= 2'd0;
      r_asm         <= 24'd0;
      r_csum        <= 8'd0;
      im_we         <= 1'b0;
      im_addr       <= '0;
      im_wdata      <= 32'd0;
      words_written <= 11'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse unless re-armed below.
      im_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state       <= S_LEN_HI;
            busy          <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            words_written <= 11'd0;
            r_bcnt        <= 2'd0;
            r_csum        <= 8'd0;
            r_widx        <= 11'd0;
            im_addr       <= '0;
          end
        end
        S_LEN_HI: begin
          if (byte_valid) begin
            r_len_hi <= byte_data;
            r_state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (byte_valid) begin
            if (w_len_ok) begin
              r_len   <= w_len;
              r_state <= S_DATA;
            end else begin
              err     <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
        S_DATA: begin
          if (byte_valid) begin
            r_asm  <= {r_asm[15:0], byte_data};
            r_csum <= r_csum ^ byte_data;
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              im_we         <= 1'b1;
              im_wdata      <= {r_asm, byte_data};
              im_addr       <= r_widx[ADDR_W-1:0];
              words_written <= words_written + 11'd1;
              r_widx        <= r_widx + 11'd1;
              if (w_last_word) r_state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (byte_valid) begin
            if (byte_data == r_csum) done <= 1'b1;
            else                     err  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_im_loader
// Description : Self-checking bench for im_loader. Expected memory writes are
//               queued as payload is streamed and compared when im_we fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_im_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'd0;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [10:0]       words_written;
  logic              busy;
  logic              cpu_hold;
  logic              done;
  logic              err;

  im_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .words_written(words_written), .busy(busy), .cpu_hold(cpu_hold),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          pass_cnt = 0;
  int          check_cnt = 0;
  int          we_count = 0;
  bit          stall_seen = 0;
  logic [41:0] exp_q[$];   // {addr, data}
  logic [41:0] exp_e;
  logic [31:0] fw[$];      // payload words of the next frame

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && im_we) begin
      we_count++;
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write addr=%0h data=%h", im_addr, im_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        if ({im_addr, im_wdata} !== exp_e)
          $display("FAIL write got addr=%0h data=%h exp addr=%0h data=%h",
                   im_addr, im_wdata, exp_e[41:32], exp_e[31:0]);
        else pass_cnt++;
      end
    end
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; returns #1 after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      @(negedge clk); byte_valid = 1'b0;
      repeat (gap) @(posedge clk);
    end
    @(negedge clk); byte_valid = 1'b1; byte_data = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      stall_seen = 1'b1;
      @(negedge clk); n++;
    end
    if (!byte_ready) begin
      check_cnt++;
      $display("FAIL byte_timeout byte=%h ready=%b exp=1", b, byte_ready);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  // Stream a whole frame built from fw[]; queues expected writes as it goes.
  task automatic send_frame(input int gap, input bit bad_cs, input logic [7:0] bad_val,
                            input bit start_mid);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [15:0] n16;
    int          n;
    cs  = 8'd0;
    n   = fw.size();
    n16 = 16'(n);
    stall_seen = 1'b0;
    do_start();
    send_byte(n16[15:8], gap);
    send_byte(n16[7:0], gap);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        b  = fw[i][31-8*j -: 8];
        cs = cs ^ b;
        if (j == 3) exp_q.push_back({10'(i), fw[i]});
        if (start_mid && i == 0 && j == 2) start = 1'b1;
        send_byte(b, gap);
        start = 1'b0;
        if (j == 3) begin
          check_cnt++;
          if (im_we !== 1'b1 || im_addr !== 10'(i))
            $display("FAIL write_latency word=%0d we=%b addr=%0h exp we=1 addr=%0h",
                     i, im_we, im_addr, i);
          else pass_cnt++;
        end
      end
    end
    send_byte(bad_cs ? bad_val : cs, gap);
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_cnt++;
    if ({im_we, im_addr, im_wdata, words_written, busy, cpu_hold, done, err, byte_ready} !== '0)
      $display("FAIL reset_state got we=%b addr=%0h wd=%h ww=%0d busy=%b hold=%b done=%b err=%b rdy=%b exp all 0",
               im_we, im_addr, im_wdata, words_written, busy, cpu_hold, done, err, byte_ready);
    else pass_cnt++;
    reset_n = 1'b1;
  endtask

  // Checks common to the end of a frame: status in FIN, then idle one cycle later.
  task automatic test_single_word();
    fw = '{32'h24080005};
    send_frame(0, 1'b0, 8'h00, 1'b0);
    check_cnt++;
    if (done !== 1'b1 || err !== 1'b0 || words_written !== 11'd1 || busy !== 1'b1)
      $display("FAIL single_fin done=%b err=%b ww=%0d busy=%b exp 1 0 1 1", done, err, words_written, busy);
    else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b1 || exp_q.size() != 0)
      $display("FAIL single_idle busy=%b hold=%b done=%b pending=%0d exp 0 0 1 0", busy, cpu_hold, done, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    fw = '{32'h3C011234, 32'h34210001, 32'h00000000};
    send_frame(0, 1'b0, 8'h00, 1'b0);
    check_cnt++;
    if (stall_seen !== 1'b0 || done !== 1'b1 || err !== 1'b0 || words_written !== 11'd3)
      $display("FAIL b2b stall=%b done=%b err=%b ww=%0d exp 0 1 0 3", stall_seen, done, err, words_written);
    else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++;
    if (exp_q.size() != 0 || busy !== 1'b0)
      $display("FAIL b2b_drain pending=%0d busy=%b exp 0 0", exp_q.size(), busy);
    else pass_cnt++;
  endtask

  task automatic test_bad_checksum();
    fw = '{32'h24080005};
    send_frame(0, 1'b1, 8'h00, 1'b0);
    check_cnt++;
    if (done !== 1'b0 || err !== 1'b1 || words_written !== 11'd1)
      $display("FAIL bad_cs done=%b err=%b ww=%0d exp 0 1 1", done, err, words_written);
    else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++;
    if (err !== 1'b1 || busy !== 1'b0)
      $display("FAIL bad_cs_hold err=%b busy=%b exp 1 0", err, busy);
    else pass_cnt++;
  endtask

  task automatic test_bad_length(input logic [7:0] hi, input logic [7:0] lo);
    int  we0;
    bit  rdy_seen;
    we0 = we_count;
    rdy_seen = 1'b0;
    do_start();
    send_byte(hi, 0);
    send_byte(lo, 0);
    check_cnt++;
    if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || byte_ready !== 1'b0)
      $display("FAIL bad_len_%h%h err=%b done=%b busy=%b rdy=%b exp 1 0 1 0", hi, lo, err, done, busy, byte_ready);
    else pass_cnt++;
    // Keep offering bytes: none may be taken once the frame is rejected.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (byte_ready) rdy_seen = 1'b1;
    end
    byte_valid = 1'b0;
    check_cnt++;
    if (rdy_seen || we_count != we0 || busy !== 1'b0 || err !== 1'b1)
      $display("FAIL bad_len_after rdy_seen=%b writes=%0d busy=%b err=%b exp 0 0 0 1",
               rdy_seen, we_count - we0, busy, err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_data();
    logic [7:0] pay[6];
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int k = 0; k < 6; k++) begin
      if (k == 3) exp_q.push_back({10'd0, 32'h11223344});
      send_byte(pay[k], 0);
    end
    @(negedge clk);
    #2 reset_n = 1'b0; byte_valid = 1'b0;
    #1;
    check_cnt++;
    if ({im_we, im_addr, im_wdata, words_written, busy, cpu_hold, done, err, byte_ready} !== '0)
      $display("FAIL async_reset we=%b addr=%0h wd=%h ww=%0d busy=%b hold=%b done=%b err=%b rdy=%b exp all 0",
               im_we, im_addr, im_wdata, words_written, busy, cpu_hold, done, err, byte_ready);
    else pass_cnt++;
    check_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL reset_partial pending=%0d exp 0", exp_q.size());
    else pass_cnt++;
    @(negedge clk); reset_n = 1'b1;
    fw = '{32'hDEADBEEF, 32'h00000013, 32'hCAFEF00D};
    send_frame(0, 1'b0, 8'h00, 1'b0);
    check_cnt++;
    if (done !== 1'b1 || err !== 1'b0 || words_written !== 11'd3)
      $display("FAIL reload done=%b err=%b ww=%0d exp 1 0 3", done, err, words_written);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_start_mid_data();
    fw = '{32'h01020304, 32'hA5A55A5A};
    send_frame(0, 1'b0, 8'h00, 1'b1);
    check_cnt++;
    if (done !== 1'b1 || err !== 1'b0 || words_written !== 11'd2)
      $display("FAIL start_mid done=%b err=%b ww=%0d exp 1 0 2", done, err, words_written);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_bytes();
    bit rdy_seen;
    rdy_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); byte_valid = 1'b1; byte_data = 8'hEE;
      if (byte_ready) rdy_seen = 1'b1;
    end
    @(negedge clk); byte_valid = 1'b0;
    check_cnt++;
    if (rdy_seen || busy !== 1'b0 || done !== 1'b1)
      $display("FAIL idle_bytes rdy_seen=%b busy=%b done=%b exp 0 0 1", rdy_seen, busy, done);
    else pass_cnt++;
  endtask

  task automatic test_gaps();
    fw = '{32'h3C011234, 32'h34210001, 32'h00000000};
    send_frame(3, 1'b0, 8'h00, 1'b0);
    check_cnt++;
    if (done !== 1'b1 || err !== 1'b0 || words_written !== 11'd3)
      $display("FAIL gaps done=%b err=%b ww=%0d exp 1 0 3", done, err, words_written);
    else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++;
    if (exp_q.size() != 0 || busy !== 1'b0)
      $display("FAIL gaps_drain pending=%0d busy=%b exp 0 0", exp_q.size(), busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_bad_checksum();
    test_bad_length(8'h00, 8'h00);
    test_bad_length(8'h04, 8'h01);
    test_reset_mid_data();
    test_start_mid_data();
    test_idle_bytes();
    test_gaps();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
`default_nettype wire
